mat_server: RTL and testbench



---
 rtl/mat_server.sv | 125 ++++++++++++
 tb/tb_mat_server.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mat_server.sv
// Matrix load/serve buffer: loads N_ELEM words, kicks the engine, serves N_RD reads.
// Optional out-of-range read checking via MAT_SERVER_BOUNDS_CHK_EN.
module mat_server #(
  parameter int N_ELEM = 16,
  parameter int N_RD   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  input  logic        rd,
  input  logic [7:0]  addr,
  output logic        start,
  output logic [15:0] data,
  output logic        data_vld,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    KICK,
    SERVE
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  wr_ptr_q, wr_ptr_d;
  logic [8:0]  rd_cnt_q, rd_cnt_d;
  logic [15:0] data_q, data_d;
  logic        vld_q, vld_d;
  logic        we;
  logic [7:0]  waddr;
  logic        rd_acc;
  logic [15:0] rdata;
  logic [15:0] mem [256];

`ifdef MAT_SERVER_BOUNDS_CHK_EN
  logic oob;
  logic err_q, err_d;

  assign oob   = {1'b0, addr} >= 9'(N_ELEM);
  assign rdata = oob ? 16'h0000 : mem[addr];
  assign err_d = err_q | (rd_acc & oob);
  assign err   = err_q;

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
`else
  assign rdata = mem[addr];
  assign err   = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_cnt_d = rd_cnt_q;
    data_d   = data_q;
    vld_d    = 1'b0;
    we       = 1'b0;
    waddr    = wr_ptr_q;
    rd_acc   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wr_en) begin
          we       = 1'b1;
          waddr    = 8'd0;
          wr_ptr_d = 8'd1;
          state_d  = (N_ELEM == 1) ? KICK : LOAD;
        end
      end
      LOAD: begin
        if (wr_en) begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + 8'd1;
          if (wr_ptr_q == 8'(N_ELEM - 1)) state_d = KICK;
        end
      end
      KICK: begin
        rd_cnt_d = 9'd0;
        state_d  = SERVE;
      end
      SERVE: begin
        if (rd) begin
          rd_acc   = 1'b1;
          vld_d    = 1'b1;
          data_d   = rdata;
          rd_cnt_d = rd_cnt_q + 9'd1;
          // the read that completes the quota is still served
          if (rd_cnt_d == 9'(N_RD)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= 8'd0;
      rd_cnt_q <= 9'd0;
      data_q   <= 16'h0000;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_cnt_q <= rd_cnt_d;
      data_q   <= data_d;
      vld_q    <= vld_d;
    end
  end

  // storage survives reset
  always_ff @(posedge clk) begin
    if (we && !rst) mem[waddr] <= wr_data;
  end

  assign start    = (state_q == KICK);
  assign busy     = (state_q != IDLE);
  assign data     = data_q;
  assign data_vld = vld_q;

endmodule

// File: tb/tb_mat_server.sv
// Bench for mat_server: directed scenarios plus random traffic against a
// transaction-level model of load/kick/serve behaviour.
module tb_mat_server;

  localparam int NE = 16;
  localparam int NR = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        rd;
  logic [7:0]  addr;
  logic        start;
  logic [15:0] data;
  logic        data_vld;
  logic        busy;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  mat_server #(.N_ELEM(NE), .N_RD(NR)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd       (rd),
    .addr     (addr),
    .start    (start),
    .data     (data),
    .data_vld (data_vld),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  // model: phase 0 idle, 1 loading, 2 kick, 3 serving
  logic [15:0] m_mem [256];
  bit          m_known [256];
  int          m_phase = 0;
  int          m_cnt = 0;
  int          m_reads = 0;
  logic [15:0] m_data = 16'h0000;
  bit          m_dknown = 1'b1;
  bit          m_vld = 1'b0;
  bit          m_err = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_cnt = 0; m_reads = 0;
      m_data = 16'h0000; m_dknown = 1'b1;
      m_vld = 1'b0; m_err = 1'b0;
    end else begin
      m_vld = 1'b0;
      case (m_phase)
        0: if (wr_en) begin
          m_mem[0] = wr_data; m_known[0] = 1'b1;
          m_cnt = 1;
          m_phase = (m_cnt == NE) ? 2 : 1;
        end
        1: if (wr_en) begin
          m_mem[m_cnt] = wr_data; m_known[m_cnt] = 1'b1;
          m_cnt++;
          if (m_cnt == NE) m_phase = 2;
        end
        2: begin
          m_reads = 0;
          m_phase = 3;
        end
        default: if (rd) begin
          m_reads++;
          m_vld = 1'b1;
`ifdef MAT_SERVER_BOUNDS_CHK_EN
          if (int'(addr) >= NE) begin
            m_data = 16'h0000; m_dknown = 1'b1; m_err = 1'b1;
          end else begin
            m_data = m_mem[addr]; m_dknown = m_known[addr];
          end
`else
          m_data = m_mem[addr]; m_dknown = m_known[addr];
`endif
          if (m_reads == NR) m_phase = 0;
        end
      endcase
    end
  end

  task automatic cmp(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    cmp("start", 16'(start), 16'(m_phase == 2));
    cmp("busy", 16'(busy), 16'(m_phase != 0));
    cmp("data_vld", 16'(data_vld), 16'(m_vld));
    cmp("err", 16'(err), 16'(m_err));
    if (m_dknown) cmp("data", data, m_data);
  end

  task automatic cyc(input bit r, input bit we, input logic [15:0] wd,
                     input bit rv, input logic [7:0] a);
    rst = r; wr_en = we; wr_data = wd; rd = rv; addr = a;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 16'h0, 1'b0, 8'h0);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = 16'h0; rd = 1'b0; addr = 8'h0;
    cyc(1'b1, 1'b0, 16'h0, 1'b0, 8'h0);
    cyc(1'b1, 1'b1, 16'h5555, 1'b1, 8'h3);
    cmp("rst_busy", 16'(busy), 16'h0);
    cmp("rst_start", 16'(start), 16'h0);
    cmp("rst_data", data, 16'h0000);
    cmp("rst_vld", 16'(data_vld), 16'h0);
    cmp("rst_err", 16'(err), 16'h0);

    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b1, 16'(16'hAABB + i), 1'b0, 8'h0);
      if (i < 15) cmp("start_early", 16'(start), 16'h0);
    end
    cmp("start_kick", 16'(start), 16'h1);
    cmp("busy_kick", 16'(busy), 16'h1);
    idle();
    cmp("start_once", 16'(start), 16'h0);

    cyc(1'b0, 1'b0, 16'h0, 1'b1, 8'd3);
    cmp("rd3_data", data, 16'hAABE);
    cmp("rd3_vld", 16'(data_vld), 16'h1);
    idle();
    cmp("hold_vld", 16'(data_vld), 16'h0);
    cmp("hold_data", data, 16'hAABE);

    cyc(1'b0, 1'b1, 16'hDEAD, 1'b0, 8'h0);
    cmp("wr_serve_vld", 16'(data_vld), 16'h0);
    cyc(1'b0, 1'b0, 16'h0, 1'b1, 8'd0);
    cmp("mem0_kept", data, 16'hAABB);

    cyc(1'b0, 1'b0, 16'h0, 1'b1, 8'h20);
`ifdef MAT_SERVER_BOUNDS_CHK_EN
    cmp("oob_data", data, 16'h0000);
    cmp("oob_vld", 16'(data_vld), 16'h1);
    cmp("oob_err", 16'(err), 16'h1);
    idle();
    cmp("err_sticky", 16'(err), 16'h1);
`else
    cmp("oob_err_off", 16'(err), 16'h0);
    idle();
    cmp("err_off_hold", 16'(err), 16'h0);
`endif
    cyc(1'b1, 1'b0, 16'h0, 1'b0, 8'h0);
    cmp("err_rst", 16'(err), 16'h0);
    cmp("busy_rst", 16'(busy), 16'h0);

    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, 16'h1122, 1'b1, 8'h20);
      cmp("rd_load_vld", 16'(data_vld), 16'h0);
    end
    cmp("rd_load_err", 16'(err), 16'h0);
    cyc(1'b1, 1'b0, 16'h0, 1'b0, 8'h0);
    cmp("abort_busy", 16'(busy), 16'h0);
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 16'h1122, 1'b0, 8'h0);
    cmp("reload_start", 16'(start), 16'h1);
    idle();
    cyc(1'b0, 1'b0, 16'h0, 1'b1, 8'd5);
    cmp("reload_rd5", data, 16'h1122);

    cyc(1'b1, 1'b0, 16'h0, 1'b0, 8'h0);
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 16'(16'hAABB + i), 1'b0, 8'h0);
    idle();
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b0, 16'h0, 1'b1, 8'(i));
      cmp("b2b_data", data, 16'(16'hAABB + i));
      cmp("b2b_vld", 16'(data_vld), 16'h1);
      if (i < 15) cmp("b2b_busy", 16'(busy), 16'h1);
    end
    cmp("done_busy", 16'(busy), 16'h0);
    cyc(1'b0, 1'b0, 16'h0, 1'b1, 8'd2);
    cmp("idle_rd_vld", 16'(data_vld), 16'h0);
    cmp("idle_rd_data", data, 16'hAACA);

    repeat (3000) begin
      cyc($urandom_range(0, 149) == 0,
          $urandom_range(0, 3) != 0,
          16'($urandom),
          $urandom_range(0, 2) != 0,
          8'($urandom_range(0, 19)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
